seg7_scan_bcd4: RTL and testbench

- Display-side consumer of the 4-digit BCD time value (d3 d2 d1 d0 = M S S .t) produced by the stopwatch counter.
- Takes a coherent snapshot of the four digits and time-multiplexes them onto a common-anode 4-digit seven-segment display.
- Provides BCD-to-segment decode, decimal-point control and a lap/freeze function.
- Sits between the stopwatch core and the board anode/segment pins.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/bcd_to_sseg.sv | 24 ++
 rtl/seg7_scan_bcd4.sv | 80 ++++++++
 tb/tb_seg7_scan_bcd4.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment codes, bit order and default refresh count for the seven-segment scanner
package seg7_pkg;
    localparam int DEFAULT_REFRESH_CNT = 250000;
    localparam int SEG_BIT_A  = 0;
    localparam int SEG_BIT_B  = 1;
    localparam int SEG_BIT_C  = 2;
    localparam int SEG_BIT_D  = 3;
    localparam int SEG_BIT_E  = 4;
    localparam int SEG_BIT_F  = 5;
    localparam int SEG_BIT_G  = 6;
    localparam int SEG_BIT_DP = 7;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/bcd_to_sseg.sv
// bcd_to_sseg: combinational BCD to active-low {g,f,e,d,c,b,a} decode, non-BCD codes show a dash
module bcd_to_sseg
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    // lookup of the digit glyph; 10..15 fall through to the dash
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/seg7_scan_bcd4.sv
// seg7_scan_bcd4: 4-digit multiplexed seven-segment scanner with frame snapshot and lap freeze (SEG7_LZB_EN blanks a leading zero on digit 3)
module seg7_scan_bcd4
    import seg7_pkg::*;
#(
    parameter int REFRESH_CNT = DEFAULT_REFRESH_CNT,
    parameter int CNT_W       = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic [3:0] dp_in,
    input  logic       lap,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic       frozen
);
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       idx_q, idx_d;
    logic             frozen_q, frozen_d, lap_q, lap_d;
    logic [3:0][3:0]  snap_q, snap_d;
    logic [3:0]       snap_dp_q, snap_dp_d, an_q, an_d;
    logic [7:0]       sseg_q, sseg_d;
    logic             scan_tick, lap_rise, load;
    logic [6:0]       cur_seg;

    bcd_to_sseg u_dec (.bcd(snap_q[idx_q]), .seg(cur_seg));

    // scan timing, lap edge toggle and atomic frame-boundary snapshot; a lap edge always wins over a load
    always_comb begin
        scan_tick = count_q == CNT_W'(REFRESH_CNT - 1);
        lap_rise  = lap & ~lap_q;
        load      = scan_tick & (idx_q == 2'd3) & ~frozen_q & ~lap_rise;
        count_d   = scan_tick ? '0 : count_q + 1'b1;
        idx_d     = idx_q + {1'b0, scan_tick};
        frozen_d  = frozen_q ^ lap_rise;
        lap_d     = lap;
        snap_d    = load ? {d3, d2, d1, d0} : snap_q;
        snap_dp_d = load ? dp_in : snap_dp_q;
    end

    // pin drive for the digit currently selected, registered one cycle behind the index
    always_comb begin
`ifdef SEG7_LZB_EN
        an_d = (idx_q == 2'd3 && snap_q[3] == 4'd0) ? 4'b1111 : ~(4'b0001 << idx_q);
`else
        an_d = ~(4'b0001 << idx_q);
`endif
        sseg_d = {~snap_dp_q[idx_q], cur_seg};
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            idx_q     <= '0;
            frozen_q  <= 1'b0;
            lap_q     <= 1'b0;
            snap_q    <= '0;
            snap_dp_q <= '0;
            an_q      <= 4'b1110;
            sseg_q    <= {1'b1, SEG_0};
        end else begin
            count_q   <= count_d;
            idx_q     <= idx_d;
            frozen_q  <= frozen_d;
            lap_q     <= lap_d;
            snap_q    <= snap_d;
            snap_dp_q <= snap_dp_d;
            an_q      <= an_d;
            sseg_q    <= sseg_d;
        end
    end

    assign an     = an_q;
    assign sseg   = sseg_q;
    assign frozen = frozen_q;
endmodule

// File: tb/tb_seg7_scan_bcd4.sv
// tb_seg7_scan_bcd4: directed stimulus with a cycle-count based display model checked every cycle
module tb_seg7_scan_bcd4;
    localparam int R = 4;
    localparam int FRAME = 4 * R;
    localparam logic [6:0] DEC [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                                        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    logic       clk = 0, reset = 1, lap = 0;
    logic [3:0] d3 = 1, d2 = 2, d1 = 3, d0 = 4, dp_in = 0;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       frozen;
    int n_checks = 0, n_fail = 0;

    seg7_scan_bcd4 #(.REFRESH_CNT(R), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
        .dp_in(dp_in), .lap(lap), .an(an), .sseg(sseg), .frozen(frozen)
    );

    always #5 clk = ~clk;

    // model: elapsed cycles since reset give the digit; the snapshot is what was seen at the last unfrozen frame end
    int         m_t, m_idx;
    logic [3:0] m_snap [4];
    logic [3:0] m_dp, e_an;
    logic [7:0] e_sseg;
    logic       m_frozen, m_lap_prev, m_rise;
    bit         started = 0;

    always @(posedge clk) begin
        started = 1;
        if (reset) begin
            m_t = 0; m_dp = 0; m_frozen = 0; m_lap_prev = 0;
            for (int i = 0; i < 4; i++) m_snap[i] = 0;
            e_an = 4'b1110; e_sseg = 8'b1100_0000;
        end else begin
            m_idx = (m_t / R) % 4;
            e_an = 4'b1111;
            e_an[m_idx] = 1'b0;
`ifdef SEG7_LZB_EN
            if (m_idx == 3 && m_snap[3] == 0) e_an = 4'b1111;
`endif
            e_sseg = {~m_dp[m_idx], DEC[m_snap[m_idx]]};
            m_rise = lap && !m_lap_prev;
            if ((m_t % FRAME) == FRAME - 1 && !m_frozen && !m_rise) begin
                m_snap[0] = d0; m_snap[1] = d1; m_snap[2] = d2; m_snap[3] = d3; m_dp = dp_in;
            end
            if (m_rise) m_frozen = !m_frozen;
            m_lap_prev = lap;
            m_t++;
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("model_an", {4'b0, an}, {4'b0, e_an});
            chk("model_sseg", sseg, e_sseg);
            chk("model_frozen", {7'b0, frozen}, {7'b0, m_frozen});
        end
    end

    task automatic wait_an(input logic [3:0] a);
        int k = 0;
        @(negedge clk);
        while (an !== a && k < 64) begin @(negedge clk); k++; end
        if (an !== a) begin
            n_checks++; n_fail++;
            $display("FAIL wait_an: got %b expected %b", an, a);
        end
    endtask

    task automatic wait_boundary();
        int k = 0;
        @(negedge clk);
        while ((m_t % FRAME) != FRAME - 1 && k < 64) begin @(negedge clk); k++; end
        if ((m_t % FRAME) != FRAME - 1) begin
            n_checks++; n_fail++;
            $display("FAIL wait_boundary: got t=%0d expected t mod %0d = %0d", m_t, FRAME, FRAME - 1);
        end
    endtask

    task automatic pulse_lap();
        lap = 1;
        @(negedge clk);
        lap = 0;
    endtask

    initial begin
        int hits;
        @(negedge clk);
        chk("reset_an", {4'b0, an}, 8'b0000_1110);
        chk("reset_sseg", sseg, 8'b1100_0000);
        chk("reset_frozen", {7'b0, frozen}, 8'd0);
        @(negedge clk);
        reset = 0;
        repeat (FRAME + 2) @(negedge clk);
        wait_an(4'b1110); chk("first_d0", sseg, 8'b1001_1001);
        wait_an(4'b1101); chk("first_d1", sseg, 8'b1011_0000);
        wait_an(4'b1011); chk("first_d2", sseg, 8'b1010_0100);
        wait_an(4'b0111); chk("first_d3", sseg, 8'b1111_1001);
        wait_an(4'b1101);
        d0 = 7;
        wait_an(4'b1110); chk("mid_frame_d0", sseg, 8'b1111_1000);
        pulse_lap();
        chk("lap1_frozen", {7'b0, frozen}, 8'd1);
        {d3, d2, d1, d0} = 16'h9999;
        repeat (2 * FRAME) @(negedge clk);
        wait_an(4'b1110); chk("held_d0", sseg, 8'b1111_1000);
        wait_an(4'b0111); chk("held_d3", sseg, 8'b1111_1001);
        pulse_lap();
        chk("lap2_frozen", {7'b0, frozen}, 8'd0);
        repeat (FRAME + 4) @(negedge clk);
        wait_an(4'b1110); chk("thaw_d0", sseg, 8'b1001_0000);
        wait_an(4'b0111); chk("thaw_d3", sseg, 8'b1001_0000);
        d1 = 4'hB; dp_in = 4'b0010;
        repeat (FRAME + 4) @(negedge clk);
        wait_an(4'b1101); chk("dash_dp_d1", sseg, 8'b0011_1111);
        wait_an(4'b1011); chk("dp_off_d2", sseg, 8'b1001_0000);
        wait_boundary();
        pulse_lap();
        chk("bnd_freeze", {7'b0, frozen}, 8'd1);
        d0 = 5;
        repeat (FRAME + 4) @(negedge clk);
        wait_an(4'b1110); chk("bnd_held_d0", sseg, 8'b1001_0000);
        wait_boundary();
        pulse_lap();
        chk("bnd_thaw", {7'b0, frozen}, 8'd0);
        wait_an(4'b1110); chk("bnd_no_load", sseg, 8'b1001_0000);
        repeat (FRAME + 2) @(negedge clk);
        wait_an(4'b1110); chk("bnd_next_load", sseg, 8'b1001_0010);
        pulse_lap();
        wait_an(4'b1011);
        reset = 1;
        @(negedge clk);
        chk("midreset_an", {4'b0, an}, 8'b0000_1110);
        chk("midreset_sseg", sseg, 8'b1100_0000);
        chk("midreset_frozen", {7'b0, frozen}, 8'd0);
        reset = 0;
        repeat (FRAME + 2) @(negedge clk);
        wait_an(4'b1110); chk("post_reset_d0", sseg, 8'b1001_0010);
        d3 = 0;
        repeat (FRAME + 4) @(negedge clk);
        hits = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (an == 4'b0111) hits++;
        end
`ifdef SEG7_LZB_EN
        chk("lzb_dark_hits", 8'(hits), 8'd0);
`else
        chk("no_lzb_hits", 8'(hits), 8'(2 * R));
`endif
        d3 = 5;
        repeat (FRAME + 4) @(negedge clk);
        wait_an(4'b0111); chk("d3_five", sseg, 8'b1001_0010);
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
